block_avg_reducer: RTL and testbench

Reduction engine upstream of the framebuffer RAM. On a start pulse it reads the 160x120 original image from the ROM and writes a box-filtered reduction into the RAM. Each output pixel is the truncated mean of an FxF source block, F = 2 or 4. The display controller then scans the result through the RAM path when the reduction opcode is active.

---
 rtl/block_avg_reducer.sv | 218 +++++++++++++++++++++
 tb/tb_block_avg_reducer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/block_avg_reducer.sv
// Box-filter reducer: reads the source image from ROM and writes FxF block means (F=2/4) to RAM.
// Latency: F*F+ROM_LAT+1 cycles per output pixel; busy spans exactly N pixels of that.
// No backpressure: ROM answers at a fixed latency and RAM accepts one write per pixel.
module block_avg_reducer #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fator_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = DATA_W + 4;
  localparam int XW    = $clog2(IMG_W / 2);
  localparam int YW    = $clog2(IMG_H / 2);

  localparam logic [XW-1:0] OW2_M1 = XW'(IMG_W / 2 - 1);
  localparam logic [XW-1:0] OW4_M1 = XW'(IMG_W / 4 - 1);
  localparam logic [YW-1:0] OH2_M1 = YW'(IMG_H / 2 - 1);
  localparam logic [YW-1:0] OH4_M1 = YW'(IMG_H / 4 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_f4;          // latched factor: 1 -> F=4, 0 -> F=2
  logic [XW-1:0]      r_ox;
  logic [YW-1:0]      r_oy;
  logic [1:0]         r_i;           // column tap inside the block
  logic [1:0]         r_j;           // row tap inside the block
  logic [1:0]         r_wcnt;        // drain counter for the ROM pipeline
  logic [ACC_W-1:0]   r_acc;
  logic [ADDR_W-1:0]  r_oaddr;       // running oy*OW+ox
  logic [ADDR_W-1:0]  r_row_base;    // source address of the first block in this output row
  logic [ADDR_W-1:0]  r_blk_base;    // source address of the block's top-left pixel
  logic [ADDR_W-1:0]  r_line;        // source address of the current tap row's first pixel
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [ADDR_W-1:0]  r_wraddr;
  logic [DATA_W-1:0]  r_data;
  logic               r_wren;
  logic               r_busy;
  logic               r_done;
  logic [ROM_LAT-1:0] r_tok;         // read tokens travelling alongside the ROM latency

  logic [1:0]         w_fm1;
  logic [XW-1:0]      w_ow_m1;
  logic [YW-1:0]      w_oh_m1;
  logic               w_last_pix;
  logic               w_last_tap;
  logic               w_row_end;
  logic [ADDR_W-1:0]  w_row_step;
  logic [ADDR_W-1:0]  w_col_step;
  logic [ADDR_W-1:0]  w_line_next;
  logic [ADDR_W-1:0]  w_next_base;
  logic               w_issue;
  logic               w_arrive;
  logic [ACC_W-1:0]   w_acc_next;
  logic [DATA_W-1:0]  w_result;

  assign w_fm1       = r_f4 ? 2'd3 : 2'd1;
  assign w_ow_m1     = r_f4 ? OW4_M1 : OW2_M1;
  assign w_oh_m1     = r_f4 ? OH4_M1 : OH2_M1;
  assign w_row_end   = (r_ox == w_ow_m1);
  assign w_last_pix  = w_row_end && (r_oy == w_oh_m1);
  assign w_last_tap  = (r_i == w_fm1) && (r_j == w_fm1);
  assign w_row_step  = r_f4 ? ADDR_W'(4 * IMG_W) : ADDR_W'(2 * IMG_W);
  assign w_col_step  = r_f4 ? ADDR_W'(4) : ADDR_W'(2);
  assign w_line_next = r_line + ADDR_W'(IMG_W);
  assign w_next_base = w_row_end ? (r_row_base + w_row_step) : (r_blk_base + w_col_step);

  assign w_issue    = (r_state == S_ISSUE);
  assign w_arrive   = r_tok[ROM_LAT-1];
  assign w_acc_next = r_acc + (w_arrive ? ACC_W'(rom_data) : '0);
  // Mean of F*F samples is a plain shift; the low bits are dropped (truncation).
  assign w_result   = r_f4 ? DATA_W'(w_acc_next >> 4) : DATA_W'(w_acc_next >> 2);

  // Token shift register: marks which cycles carry valid rom_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tok <= '0;
    end else begin
      r_tok[0] <= w_issue;
      for (int k = 1; k < ROM_LAT; k++) begin
        r_tok[k] <= r_tok[k-1];
      end
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_f4       <= 1'b0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_wcnt     <= '0;
      r_acc      <= '0;
      r_oaddr    <= '0;
      r_row_base <= '0;
      r_blk_base <= '0;
      r_line     <= '0;
      r_rom_addr <= '0;
      r_wraddr   <= '0;
      r_data     <= '0;
      r_wren     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      r_done <= 1'b0;
      r_acc  <= w_acc_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f4       <= fator_sel;
            r_ox       <= '0;
            r_oy       <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_acc      <= '0;
            r_oaddr    <= '0;
            r_row_base <= '0;
            r_blk_base <= '0;
            r_line     <= '0;
            r_rom_addr <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (w_last_tap) begin
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end else if (r_i == w_fm1) begin
            r_i        <= '0;
            r_j        <= r_j + 2'd1;
            r_line     <= w_line_next;
            r_rom_addr <= w_line_next;
          end else begin
            r_i        <= r_i + 2'd1;
            r_rom_addr <= r_rom_addr + ADDR_W'(1);
          end
        end

        S_WAIT: begin
          // The last sample lands in the final drain cycle, so the result uses w_acc_next.
          if (r_wcnt == 2'(ROM_LAT - 1)) begin
            r_wren   <= 1'b1;
            r_wraddr <= r_oaddr;
            r_data   <= w_result;
            r_acc    <= '0;
            r_state  <= S_WRITE;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end

        S_WRITE: begin
          r_oaddr <= r_oaddr + ADDR_W'(1);
          if (w_last_pix) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_row_end) begin
              r_ox       <= '0;
              r_oy       <= r_oy + YW'(1);
              r_row_base <= w_next_base;
            end else begin
              r_ox <= r_ox + XW'(1);
            end
            r_blk_base <= w_next_base;
            r_line     <= w_next_base;
            r_rom_addr <= w_next_base;
            r_i        <= '0;
            r_j        <= '0;
            r_state    <= S_ISSUE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign ram_wraddr = r_wraddr;
  assign ram_data   = r_data;
  assign ram_wren   = r_wren;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_block_avg_reducer.sv
// Directed bench for block_avg_reducer: ROM model with selectable content, write monitor, pass checks.
// Expected pixel values come from a direct block-sum formula and hand-computed constants.
// Waits on the DUT are all cycle-bounded.
module tb_block_avg_reducer;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              fator_sel = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  block_avg_reducer #(
    .IMG_W(160), .IMG_H(120), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fator_sel(fator_sel),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done)
  );

  // ROM content: 0 -> constant 100, 1 -> addr[7:0], 2 -> 255 except 254 at address 161
  int mode = 0;
  int tb_f = 2;
  int pass_base = 0;

  int wr_cnt = 0, bad_addr = 0, bad_data = 0, busy_cyc = 0;
  int done_cnt = 0, done_bad = 0, last_wraddr = 0;
  int wdat[4];
  logic prev_busy = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  function automatic int rom_val(int a);
    case (mode)
      0:       return 100;
      1:       return a & 255;
      default: return (a == 161) ? 254 : 255;
    endcase
  endfunction

  function automatic int exp_pix(int k, int f);
    int ow, ox, oy, s;
    ow = 160 / f;
    ox = k % ow;
    oy = k / ow;
    s  = 0;
    for (int j = 0; j < f; j++)
      for (int i = 0; i < f; i++)
        s += rom_val((oy * f + j) * 160 + ox * f + i);
    return (f == 2) ? (s >> 2) : (s >> 4);
  endfunction

  // One-cycle-latency ROM
  always @(posedge clk) rom_data <= 8'(rom_val(int'(rom_addr)));

  // Write/busy/done monitor, sampled on the falling edge
  always @(negedge clk) begin
    int idx;
    if (ram_wren) begin
      idx = wr_cnt - pass_base;
      if (int'(ram_wraddr) != idx) bad_addr++;
      if (int'(ram_data) != exp_pix(idx, tb_f)) bad_data++;
      if (idx < 4) wdat[idx] = int'(ram_data);
      last_wraddr = int'(ram_wraddr);
      wr_cnt++;
    end
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      if (!(prev_busy && !busy)) done_bad++;
    end
    prev_busy = busy;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  function automatic int outs_nonzero();
    return int'(|{rom_addr, ram_wraddr, ram_data, ram_wren, busy, done});
  endfunction

  task automatic run_pass(input string tag, input int m, input int f, input int exp_wr,
                          input int exp_last, input int exp_busy, input int exp_d0,
                          input int exp_d1, input bit disturb);
    int ba, bd, bb, dc, db, n;
    mode = m;
    tb_f = f;
    fator_sel = (f == 4);
    pass_base = wr_cnt;
    ba = bad_addr; bd = bad_data; bb = busy_cyc; dc = done_cnt; db = done_bad;
    pulse_start();
    if (disturb) begin
      for (int k = 0; k < 5; k++) begin
        repeat (3000) @(negedge clk);
        start = 1'b1;
        fator_sel = ~fator_sel;
        @(negedge clk);
        start = 1'b0;
      end
    end
    n = 0;
    while (done_cnt == dc && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, int'(done_cnt != dc), 1);
    repeat (20) @(posedge clk);
    check({tag, "_writes"}, wr_cnt - pass_base, exp_wr);
    check({tag, "_bad_addr"}, bad_addr - ba, 0);
    check({tag, "_bad_data"}, bad_data - bd, 0);
    check({tag, "_last_addr"}, last_wraddr, exp_last);
    check({tag, "_busy_cycles"}, busy_cyc - bb, exp_busy);
    check({tag, "_done_pulses"}, done_cnt - dc, 1);
    check({tag, "_done_on_busy_fall"}, done_bad - db, 0);
    check({tag, "_pix0"}, wdat[0], exp_d0);
    check({tag, "_pix1"}, wdat[1], exp_d1);
  endtask

  initial begin
    int n, bb, dc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs_zero", outs_nonzero(), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_no_writes", wr_cnt, 0);

    // Truncation pattern, then reset during the 100th output pixel
    mode = 2;
    tb_f = 2;
    fator_sel = 1'b0;
    pass_base = wr_cnt;
    pulse_start();
    n = 0;
    while (wr_cnt - pass_base < 99 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("trunc_reach99", wr_cnt - pass_base, 99);
    check("trunc_254", wdat[0], 254);
    check("full_255", wdat[1], 255);
    check("trunc_bad_data", bad_data, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("midrst_outs_zero", outs_nonzero(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bb = busy_cyc;
    dc = done_cnt;
    repeat (60) @(negedge clk);
    #1;
    check("postrst_writes", wr_cnt - pass_base, 99);
    check("postrst_busy", busy_cyc - bb, 0);
    check("postrst_done", done_cnt - dc, 0);

    // Full passes
    run_pass("const_f2", 0, 2, 4800, 4799, 28800, 100, 100, 1'b0);
    run_pass("addr_f2_disturb", 1, 2, 4800, 4799, 28800, 80, 82, 1'b1);
    run_pass("addr_f4", 1, 4, 1200, 1199, 21600, 113, 117, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
